// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver and its receive-side FIFO.
package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int BAUD_TICK      = 5208;
  localparam int RX_FIFO_DEPTH  = 16;
  localparam int RX_FIFO_ADDR_W = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Generic pointer-and-array FIFO; the caller decides when a push or pop is legal.
module sync_fifo_core #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: drops bytes arriving into a full FIFO, flags them with a
// sticky overflow bit, and presents the head byte first-word-fall-through.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] in_data,
  input  logic                   in_valid,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  uart_byte_t head;
  logic       push;
  logic       pop;
  logic       drop;
  logic       overflow_q, overflow_d;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  sync_fifo_core #(
    .WIDTH  (UART_DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = ~empty;
  assign out_data  = out_valid ? head : '0;
  assign overflow  = overflow_q;

endmodule
